tdc_thermo_encoder: RTL

Downstream stage of the CARRY4 delay line. Samples the raw tap bus (CO outputs) every clock and resynchronises it. Applies bubble correction and converts the thermometer snapshot into a binary fine code. On each trigger rising edge it emits one timestamp {coarse, fine} through a valid/ready handshake to the readout logic.

---
 rtl/tdc_thermo_encoder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tdc_thermo_encoder.sv
// CARRY4 delay-line back end: resync taps, bubble-correct, popcount to a fine code,
// and emit one {coarse, fine} timestamp per trigger edge over valid/ready.

module tdc_bubble_cell (
    input  logic lo,
    input  logic mid,
    input  logic hi,
    output logic c
);
    assign c = (lo & mid) | (lo & hi) | (mid & hi);
endmodule

module tdc_thermo_encoder #(
    parameter int NTAPS   = 32,
    parameter int FINEW   = 6,
    parameter int COARSEW = 16,
    parameter int DROPW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NTAPS-1:0]   tap_in,
    input  logic               arm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COARSEW-1:0] out_coarse,
    output logic [FINEW-1:0]   out_fine,
    output logic               out_ovf,
    output logic [DROPW-1:0]   drop_cnt,
    output logic [1:0]         state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HOLD = 2'd2} state_t;

    localparam int STAGES = 3;
    localparam logic [FINEW-1:0] FULL = FINEW'(NTAPS);

    logic [COARSEW-1:0] coarse, s1_coarse, s2_coarse, s3_coarse;
    logic [NTAPS-1:0]   s1_taps, s2_taps, corr;
    logic [FINEW-1:0]   pop, s3_fine;
    logic [STAGES:0]    vld_pipe;
    logic               prev_zero, hit;
    logic               load, ack, drop_inc;
    state_t             state, state_n;

    // Per-tap majority vote; chain ends replicate their own tap.
    for (genvar i = 0; i < NTAPS; i++) begin : g_cell
        localparam int LO = (i == 0) ? 0 : i - 1;
        localparam int HI = (i == NTAPS - 1) ? NTAPS - 1 : i + 1;
        tdc_bubble_cell u_cell (
            .lo  (s2_taps[LO]),
            .mid (s2_taps[i]),
            .hi  (s2_taps[HI]),
            .c   (corr[i])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NTAPS; i++) pop = pop + FINEW'(corr[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse    <= '0;
            s1_coarse <= '0;
            s2_coarse <= '0;
            s3_coarse <= '0;
            s1_taps   <= '0;
            s2_taps   <= '0;
            s3_fine   <= '0;
            vld_pipe  <= '0;
            prev_zero <= 1'b0;
        end else begin
            coarse    <= coarse + COARSEW'(1);
            s1_taps   <= tap_in;
            s1_coarse <= coarse;
            s2_taps   <= s1_taps;
            s2_coarse <= s1_coarse;
            s3_fine   <= pop;
            s3_coarse <= s2_coarse;
            vld_pipe  <= {vld_pipe[STAGES-1:0], 1'b1};
            // Zeros flushed out of reset are not a real low trigger, so ignore them.
            prev_zero <= vld_pipe[STAGES] && (s3_fine == '0);
        end
    end

    assign hit = (s3_fine != '0) && prev_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        ack      = 1'b0;
        drop_inc = 1'b0;
        case (state)
            IDLE:  if (arm) state_n = ARMED;
            ARMED: begin
                if (hit) begin
                    load    = 1'b1;
                    state_n = HOLD;
                end else if (!arm) begin
                    state_n = IDLE;
                end
            end
            HOLD: begin
                drop_inc = hit;
                if (out_valid && out_ready) begin
                    ack     = 1'b1;
                    state_n = arm ? ARMED : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_coarse <= '0;
            out_fine   <= '0;
            out_ovf    <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (load) begin
                out_valid  <= 1'b1;
                out_coarse <= s3_coarse;
                out_fine   <= s3_fine;
                out_ovf    <= (s3_fine == FULL);
            end else if (ack) begin
                out_valid  <= 1'b0;
            end
            if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROPW'(1);
        end
    end

    assign state_o = state;

endmodule
